qpu_exu_qiu_evq: RTL and testbench

Timed event queue and issue scheduler behind the QIU write-back port. It buffers quantum events (event data, event operand mask, timestamp) in arrival order. It runs a local event timer and releases each event as a one-cycle pulse when the timer reaches the event's timestamp. It sits between the QIU write-back/commit handshake and the per-qubit waveform/measurement trigger logic, and converts instruction-ordered events into time-ordered issue.

---
 rtl/qpu_exu_qiu_evq_if.sv | 30 +++
 rtl/qpu_exu_qiu_evq.sv | 146 ++++++++++++++
 tb/tb_qpu_exu_qiu_evq.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/qpu_exu_qiu_evq_if.sv
// Event-queue handshake bundle: the write-back push channel and the timed issue channel.
// The master modport is the producer/consumer side; the slave modport is the queue itself.
interface qpu_exu_qiu_evq_if #(
    parameter int EDATA_W  = 64,
    parameter int OPRAND_W = 8,
    parameter int TIME_W   = 32
);
    logic                evq_i_valid;
    logic                evq_i_ready;
    logic [EDATA_W-1:0]  evq_i_edata;
    logic [OPRAND_W-1:0] evq_i_oprand;
    logic [TIME_W-1:0]   evq_i_tdata;

    logic                evq_o_valid;
    logic [EDATA_W-1:0]  evq_o_edata;
    logic [OPRAND_W-1:0] evq_o_oprand;
    logic [TIME_W-1:0]   evq_o_time;

    modport master (
        output evq_i_valid, evq_i_edata, evq_i_oprand, evq_i_tdata,
        input  evq_i_ready,
        input  evq_o_valid, evq_o_edata, evq_o_oprand, evq_o_time
    );

    modport slave (
        input  evq_i_valid, evq_i_edata, evq_i_oprand, evq_i_tdata,
        output evq_i_ready,
        output evq_o_valid, evq_o_edata, evq_o_oprand, evq_o_time
    );
endinterface

// File: rtl/qpu_exu_qiu_evq.sv
// Timed event queue: buffers events in arrival order and releases the head as a
// one-cycle strobe once the local timer reaches its timestamp.
module qpu_exu_qiu_evq #(
    parameter int EDATA_W  = 64,
    parameter int OPRAND_W = 8,
    parameter int TIME_W   = 32,
    parameter int DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    qpu_exu_qiu_evq_if.slave         evq_if,
    input  logic                     evq_tmr_start,
    input  logic                     evq_tmr_stop,
    input  logic                     evq_flush,
    output logic [$clog2(DEPTH):0]   evq_count,
    output logic                     evq_late,
    output logic                     evq_busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [TIME_W-1:0]   timer_q, timer_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                late_q, late_d;
    logic                o_valid_q, o_valid_d;
    logic [EDATA_W-1:0]  o_edata_q, o_edata_d;
    logic [OPRAND_W-1:0] o_oprand_q, o_oprand_d;
    logic [TIME_W-1:0]   o_time_q, o_time_d;

    // Entry storage carries no reset; occupancy and pointers define validity.
    logic [EDATA_W-1:0]  mem_edata_q  [DEPTH];
    logic [OPRAND_W-1:0] mem_oprand_q [DEPTH];
    logic [TIME_W-1:0]   mem_tdata_q  [DEPTH];

    logic                ready;
    logic                push;
    logic                issue;
    logic [EDATA_W-1:0]  head_edata;
    logic [OPRAND_W-1:0] head_oprand;
    logic [TIME_W-1:0]   head_tdata;

    assign head_edata  = mem_edata_q[rd_ptr_q];
    assign head_oprand = mem_oprand_q[rd_ptr_q];
    assign head_tdata  = mem_tdata_q[rd_ptr_q];

    assign ready = (count_q < DEPTH_C) & ~evq_flush;
    assign push  = evq_if.evq_i_valid & ready;
    // Flush suppresses the pop so a flushed head never reaches the trigger logic.
    assign issue = (state_q == RUN) & (count_q != '0) & (head_tdata <= timer_q) & ~evq_flush;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (evq_tmr_start) begin
            state_d = RUN;
            timer_d = '0;
        end else if (evq_tmr_stop) begin
            state_d = IDLE;
        end else if (state_q == RUN) begin
            timer_d = timer_q + TIME_W'(1);
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        late_d   = late_q;
        if (evq_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            late_d   = 1'b0;
        end else begin
            if (push)
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (issue)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(issue);
            if (issue && (head_tdata < timer_q))
                late_d = 1'b1;
        end
    end

    always_comb begin
        o_valid_d  = issue;
        o_edata_d  = o_edata_q;
        o_oprand_d = o_oprand_q;
        o_time_d   = o_time_q;
        if (issue) begin
            o_edata_d  = head_edata;
            o_oprand_d = head_oprand;
            o_time_d   = timer_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            late_q     <= 1'b0;
            o_valid_q  <= 1'b0;
            o_edata_q  <= '0;
            o_oprand_q <= '0;
            o_time_q   <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            late_q     <= late_d;
            o_valid_q  <= o_valid_d;
            o_edata_q  <= o_edata_d;
            o_oprand_q <= o_oprand_d;
            o_time_q   <= o_time_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_edata_q[wr_ptr_q]  <= evq_if.evq_i_edata;
            mem_oprand_q[wr_ptr_q] <= evq_if.evq_i_oprand;
            mem_tdata_q[wr_ptr_q]  <= evq_if.evq_i_tdata;
        end
    end

    assign evq_if.evq_i_ready  = ready;
    assign evq_if.evq_o_valid  = o_valid_q;
    assign evq_if.evq_o_edata  = o_edata_q;
    assign evq_if.evq_o_oprand = o_oprand_q;
    assign evq_if.evq_o_time   = o_time_q;

    assign evq_count = count_q;
    assign evq_late  = late_q;
    assign evq_busy  = (state_q == RUN) | (count_q != '0);
endmodule

// File: tb/tb_qpu_exu_qiu_evq.sv
// Directed bench for the timed event queue: issue timing, backpressure, ordering,
// stop/restart, flush collision and asynchronous reset.
module tb_qpu_exu_qiu_evq;
    localparam int EDATA_W  = 64;
    localparam int OPRAND_W = 8;
    localparam int TIME_W   = 32;
    localparam int DEPTH    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic evq_tmr_start = 1'b0;
    logic evq_tmr_stop  = 1'b0;
    logic evq_flush     = 1'b0;
    logic [$clog2(DEPTH):0] evq_count;
    logic evq_late;
    logic evq_busy;

    int n_cmp = 0;
    int n_err = 0;

    qpu_exu_qiu_evq_if #(.EDATA_W(EDATA_W), .OPRAND_W(OPRAND_W), .TIME_W(TIME_W)) evq_bus ();

    qpu_exu_qiu_evq #(
        .EDATA_W(EDATA_W), .OPRAND_W(OPRAND_W), .TIME_W(TIME_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .evq_if(evq_bus),
        .evq_tmr_start(evq_tmr_start),
        .evq_tmr_stop(evq_tmr_stop),
        .evq_flush(evq_flush),
        .evq_count(evq_count),
        .evq_late(evq_late),
        .evq_busy(evq_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] ed, input logic [7:0] op, input logic [31:0] td);
        evq_bus.evq_i_valid  = 1'b1;
        evq_bus.evq_i_edata  = ed;
        evq_bus.evq_i_oprand = op;
        evq_bus.evq_i_tdata  = td;
        tick();
        evq_bus.evq_i_valid  = 1'b0;
    endtask

    task automatic pulse_start();
        evq_tmr_start = 1'b1;
        tick();
        evq_tmr_start = 1'b0;
    endtask

    task automatic pulse_stop();
        evq_tmr_stop = 1'b1;
        tick();
        evq_tmr_stop = 1'b0;
    endtask

    task automatic pulse_flush();
        evq_flush = 1'b1;
        tick();
        evq_flush = 1'b0;
    endtask

    // Advance until the next issue strobe, bounded by budget cycles.
    task automatic wait_issue(input string tag, input int budget, output int ticks);
        ticks = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            ticks++;
            if (evq_bus.evq_o_valid) break;
        end
        chk({tag, "_seen"}, 64'(evq_bus.evq_o_valid), 64'd1);
    endtask

    int  t;
    logic any_v;

    initial begin
        evq_bus.evq_i_valid  = 1'b0;
        evq_bus.evq_i_edata  = '0;
        evq_bus.evq_i_oprand = '0;
        evq_bus.evq_i_tdata  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_ready", 64'(evq_bus.evq_i_ready), 64'd1);
        chk("rst_valid", 64'(evq_bus.evq_o_valid), 64'd0);
        chk("rst_edata", evq_bus.evq_o_edata, 64'd0);
        chk("rst_time", 64'(evq_bus.evq_o_time), 64'd0);
        chk("rst_count", 64'(evq_count), 64'd0);
        chk("rst_late", 64'(evq_late), 64'd0);
        chk("rst_busy", 64'(evq_busy), 64'd0);

        // Basic issue: tdata 5, 9, 9 issue at times 5, 9, 10.
        push(64'hA5, 8'h01, 32'd5);
        push(64'hA9, 8'h02, 32'd9);
        push(64'hAA, 8'h04, 32'd9);
        chk("b_count3", 64'(evq_count), 64'd3);
        chk("b_busy_q", 64'(evq_busy), 64'd1);
        pulse_start();
        wait_issue("b1", 50, t);
        chk("b1_lat", 64'(t), 64'd6);
        chk("b1_time", 64'(evq_bus.evq_o_time), 64'd5);
        chk("b1_edata", evq_bus.evq_o_edata, 64'hA5);
        chk("b1_opr", 64'(evq_bus.evq_o_oprand), 64'h01);
        chk("b1_late", 64'(evq_late), 64'd0);
        wait_issue("b2", 50, t);
        chk("b2_lat", 64'(t), 64'd4);
        chk("b2_time", 64'(evq_bus.evq_o_time), 64'd9);
        chk("b2_late", 64'(evq_late), 64'd0);
        wait_issue("b3", 50, t);
        chk("b3_lat", 64'(t), 64'd1);
        chk("b3_time", 64'(evq_bus.evq_o_time), 64'd10);
        chk("b3_edata", evq_bus.evq_o_edata, 64'hAA);
        chk("b3_late", 64'(evq_late), 64'd1);
        tick();
        chk("b_valid_pulse", 64'(evq_bus.evq_o_valid), 64'd0);
        chk("b_count0", 64'(evq_count), 64'd0);
        chk("b_busy_run", 64'(evq_busy), 64'd1);
        pulse_stop();
        chk("b_busy_idle", 64'(evq_busy), 64'd0);
        chk("b_late_sticky", 64'(evq_late), 64'd1);
        pulse_flush();
        chk("b_late_flushed", 64'(evq_late), 64'd0);

        // Full/backpressure with the timer stopped.
        for (int i = 0; i < DEPTH; i++) push(64'hB0 + 64'(i), 8'(i), 32'(i));
        chk("f_ready0", 64'(evq_bus.evq_i_ready), 64'd0);
        chk("f_count8", 64'(evq_count), 64'd8);
        evq_bus.evq_i_valid  = 1'b1;
        evq_bus.evq_i_edata  = 64'hB9;
        evq_bus.evq_i_oprand = 8'h99;
        evq_bus.evq_i_tdata  = 32'd100;
        repeat (3) tick();
        chk("f_hold_count", 64'(evq_count), 64'd8);
        pulse_start();
        chk("f_start_valid", 64'(evq_bus.evq_o_valid), 64'd0);
        chk("f_start_count", 64'(evq_count), 64'd8);
        tick();
        chk("f_i0_valid", 64'(evq_bus.evq_o_valid), 64'd1);
        chk("f_i0_time", 64'(evq_bus.evq_o_time), 64'd0);
        chk("f_i0_count", 64'(evq_count), 64'd7);
        chk("f_i0_ready", 64'(evq_bus.evq_i_ready), 64'd1);
        tick();
        evq_bus.evq_i_valid = 1'b0;
        chk("f_i1_time", 64'(evq_bus.evq_o_time), 64'd1);
        chk("f_i1_count", 64'(evq_count), 64'd7);
        for (int i = 2; i < DEPTH; i++) begin
            wait_issue("f_drain", 5, t);
            chk("f_drain_time", 64'(evq_bus.evq_o_time), 64'(i));
        end
        wait_issue("f9", 200, t);
        chk("f9_time", 64'(evq_bus.evq_o_time), 64'd100);
        chk("f9_edata", evq_bus.evq_o_edata, 64'hB9);
        chk("f9_opr", 64'(evq_bus.evq_o_oprand), 64'h99);
        chk("f_late", 64'(evq_late), 64'd0);
        pulse_stop();

        // Ordering: younger smaller timestamp waits behind the head.
        push(64'hC20, 8'h10, 32'd20);
        push(64'hC03, 8'h20, 32'd3);
        pulse_start();
        wait_issue("o1", 50, t);
        chk("o1_time", 64'(evq_bus.evq_o_time), 64'd20);
        chk("o1_edata", evq_bus.evq_o_edata, 64'hC20);
        chk("o1_late", 64'(evq_late), 64'd0);
        wait_issue("o2", 50, t);
        chk("o2_lat", 64'(t), 64'd1);
        chk("o2_time", 64'(evq_bus.evq_o_time), 64'd21);
        chk("o2_late", 64'(evq_late), 64'd1);
        pulse_stop();
        pulse_flush();

        // Stop at timer=4 with head tdata=6, then restart.
        push(64'hD6, 8'h40, 32'd6);
        pulse_start();
        repeat (4) tick();
        pulse_stop();
        any_v = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            any_v = any_v | evq_bus.evq_o_valid;
        end
        chk("s_no_issue_idle", 64'(any_v), 64'd0);
        chk("s_count1", 64'(evq_count), 64'd1);
        pulse_start();
        wait_issue("s1", 50, t);
        chk("s1_lat", 64'(t), 64'd7);
        chk("s1_time", 64'(evq_bus.evq_o_time), 64'd6);
        chk("s1_late", 64'(evq_late), 64'd0);

        // Flush colliding with an issue condition and an offered event.
        push(64'hE0, 8'h01, 32'd0);
        wait_issue("x_late_ev", 5, t);
        chk("x_late_set", 64'(evq_late), 64'd1);
        push(64'hE1, 8'h02, 32'd0);
        evq_flush            = 1'b1;
        evq_bus.evq_i_valid  = 1'b1;
        evq_bus.evq_i_edata  = 64'hE2;
        evq_bus.evq_i_tdata  = 32'd0;
        #1;
        chk("x_ready_flush", 64'(evq_bus.evq_i_ready), 64'd0);
        tick();
        evq_flush           = 1'b0;
        evq_bus.evq_i_valid = 1'b0;
        chk("x_valid", 64'(evq_bus.evq_o_valid), 64'd0);
        chk("x_count", 64'(evq_count), 64'd0);
        chk("x_late", 64'(evq_late), 64'd0);
        any_v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            any_v = any_v | evq_bus.evq_o_valid;
        end
        chk("x_no_issue", 64'(any_v), 64'd0);
        chk("x_count_after", 64'(evq_count), 64'd0);

        // Asynchronous reset mid-RUN with three queued events.
        push(64'hF0, 8'h81, 32'd0);
        wait_issue("r_late_ev", 5, t);
        chk("r_late_set", 64'(evq_late), 64'd1);
        for (int i = 0; i < 3; i++) push(64'hF1 + 64'(i), 8'h0F, 32'd1000);
        chk("r_count3", 64'(evq_count), 64'd3);
        #2 rst = 1'b1;
        #1;
        chk("r_ready", 64'(evq_bus.evq_i_ready), 64'd1);
        chk("r_valid", 64'(evq_bus.evq_o_valid), 64'd0);
        chk("r_edata", evq_bus.evq_o_edata, 64'd0);
        chk("r_opr", 64'(evq_bus.evq_o_oprand), 64'd0);
        chk("r_time", 64'(evq_bus.evq_o_time), 64'd0);
        chk("r_count", 64'(evq_count), 64'd0);
        chk("r_late", 64'(evq_late), 64'd0);
        chk("r_busy", 64'(evq_busy), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("r_rel_valid", 64'(evq_bus.evq_o_valid), 64'd0);
        chk("r_rel_busy", 64'(evq_busy), 64'd0);
        push(64'hF9, 8'h3C, 32'd0);
        any_v = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            any_v = any_v | evq_bus.evq_o_valid;
        end
        chk("r_no_issue", 64'(any_v), 64'd0);
        chk("r_count1", 64'(evq_count), 64'd1);
        pulse_start();
        wait_issue("r1", 5, t);
        chk("r1_lat", 64'(t), 64'd1);
        chk("r1_time", 64'(evq_bus.evq_o_time), 64'd0);
        chk("r1_edata", evq_bus.evq_o_edata, 64'hF9);
        chk("r1_late", 64'(evq_late), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
